// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg.sv
// Shared types for the staged power-switch sequencer.
// Holds the sequencer state encoding and the level-width helper.
package gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg;

    localparam int NSTAGE_DEF = 8;
    localparam int DW_DEF     = 4;

    typedef enum logic [1:0] {
        s_off  = 2'b00,
        s_up   = 2'b01,
        s_on   = 2'b10,
        s_down = 2'b11
    } pwr_state_t;

    // Bits needed to hold a level 0..n.
    function automatic int lvl_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__therm_dec.sv
// Level to thermometer decoder; bit i is set when lvl > i.
// Ports: lvl (LW bits) in, therm (NSTAGE bits) out. Purely combinational.
module gf180mcu_fd_sc_mcu9t5v0__therm_dec #(
    parameter int NSTAGE = 8,
    parameter int LW     = 4
) (
    input  logic [LW-1:0]     lvl,
    output logic [NSTAGE-1:0] therm
);

    always_comb begin
        therm = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            therm[i] = (int'(lvl) > i);
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Staged header-switch sequencer: ramps a thermometer enable one segment per dwell.
// Ports: CLK, RN (sync low), VDD/VSS rails, REQ, DWELL in; SW, ACK, IDLE, BUSY out.
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq
    import gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              CLK,
    input  logic              RN,
    inout  wire               VDD,
    inout  wire               VSS,
    input  logic              REQ,
    input  logic [DW-1:0]     DWELL,
    output logic [NSTAGE-1:0] SW,
    output logic              ACK,
    output logic              IDLE,
    output logic              BUSY
);

    localparam int LW = lvl_w(NSTAGE);

    pwr_state_t    state_q;
    logic [LW-1:0] lvl_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] d_eff;
    logic          top_lvl;
    logic          bot_lvl;
    logic          expired;

    // Rails are carried for cell-port compatibility only.
    logic unused_rails;
    assign unused_rails = VDD ^ VSS;

    assign d_eff   = (DWELL == '0) ? DW'(1) : DWELL;
    assign top_lvl = (lvl_q == LW'(NSTAGE));
    assign bot_lvl = (lvl_q == '0);
    // cnt is never 0 while ramping; <=1 keeps the FSM safe anyway.
    assign expired = (cnt_q <= DW'(1));

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= s_off;
            lvl_q   <= '0;
            cnt_q   <= '0;
            ACK     <= 1'b0;
            IDLE    <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            unique case (state_q)
                s_off: begin
                    if (REQ) begin
                        state_q <= s_up;
                        lvl_q   <= lvl_q + LW'(1);
                        cnt_q   <= d_eff;
                        IDLE    <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                s_up: begin
                    // A request reversal beats dwell expiry.
                    if (!REQ) begin
                        state_q <= s_down;
                        lvl_q   <= lvl_q - LW'(1);
                        cnt_q   <= d_eff;
                    end else if (!expired) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else if (!top_lvl) begin
                        lvl_q <= lvl_q + LW'(1);
                        cnt_q <= d_eff;
                    end else begin
                        state_q <= s_on;
                        ACK     <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                s_on: begin
                    if (!REQ) begin
                        state_q <= s_down;
                        lvl_q   <= lvl_q - LW'(1);
                        cnt_q   <= d_eff;
                        ACK     <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                s_down: begin
                    if (REQ) begin
                        state_q <= s_up;
                        lvl_q   <= lvl_q + LW'(1);
                        cnt_q   <= d_eff;
                    end else if (!expired) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else if (!bot_lvl) begin
                        lvl_q <= lvl_q - LW'(1);
                        cnt_q <= d_eff;
                    end else begin
                        state_q <= s_off;
                        IDLE    <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // SW is a pure decode of the level register, so it is glitch-free.
    gf180mcu_fd_sc_mcu9t5v0__therm_dec #(
        .NSTAGE(NSTAGE),
        .LW    (LW)
    ) u_therm (
        .lvl  (lvl_q),
        .therm(SW)
    );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Bench for the staged power-switch sequencer (NSTAGE=4).
// Directed timing scenarios plus random REQ/DWELL/RN against a level model.
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq;

    localparam int N = 4;

    logic       clk;
    logic       rn;
    logic       req;
    logic [3:0] dwell;
    wire  [3:0] sw;
    wire        ack;
    wire        idle;
    wire        busy;
    wire        vdd;
    wire        vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    int checks = 0;
    int passes = 0;

    gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
        .NSTAGE(N),
        .DW    (4)
    ) dut (
        .CLK  (clk),
        .RN   (rn),
        .VDD  (vdd),
        .VSS  (vss),
        .REQ  (req),
        .DWELL(dwell),
        .SW   (sw),
        .ACK  (ack),
        .IDLE (idle),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rn  = 1'b0;
        req = 1'b0;
        tick();
        rn = 1'b1;
    endtask

    function automatic logic [3:0] therm(input int n);
        logic [4:0] t;
        t = (5'd1 << n) - 5'd1;
        return t[3:0];
    endfunction

    task automatic test_reset();
        rn    = 1'b0;
        req   = 1'b0;
        dwell = 4'd0;
        tick();
        tick();
        checks++;
        if ({sw, ack, idle, busy} !== {4'b0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state got sw=%b a=%b i=%b b=%b want 0000 0 1 0",
                     sw, ack, idle, busy);
        else passes++;
        rn    = 1'b1;
        dwell = 4'd3;
        req   = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        checks++;
        if (sw !== 4'b0011)
            $display("FAIL midramp_pre got sw=%b want 0011", sw);
        else passes++;
        rn = 1'b0;
        tick();
        checks++;
        if ({sw, ack, idle, busy} !== {4'b0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL midramp_reset got sw=%b a=%b i=%b b=%b want 0000 0 1 0",
                     sw, ack, idle, busy);
        else passes++;
        req = 1'b0;
        rn  = 1'b1;
    endtask

    task automatic test_ramp_up_down();
        logic [3:0] esw;
        int n;
        do_reset();
        dwell = 4'd2;
        req   = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (e <= 8) begin
                n   = (e / 2 + 1 > N) ? N : e / 2 + 1;
                esw = therm(n);
                checks++;
                if (sw !== esw || ack !== (e >= 8))
                    $display("FAIL ramp_up e=%0d got sw=%b ack=%b want sw=%b ack=%b",
                             e, sw, ack, esw, e >= 8);
                else passes++;
            end
        end
        req = 1'b0;
        for (int e = 20; e <= 28; e++) begin
            tick();
            n   = 3 - (e - 20) / 2;
            n   = (n < 0) ? 0 : n;
            esw = therm(n);
            checks++;
            if (sw !== esw || ack !== 1'b0 || idle !== (e >= 28))
                $display("FAIL ramp_down e=%0d got sw=%b ack=%b idle=%b want sw=%b 0 %b",
                         e, sw, ack, idle, esw, e >= 28);
            else passes++;
        end
    endtask

    task automatic test_dwell_zero();
        logic [3:0] esw;
        int n;
        do_reset();
        dwell = 4'd0;
        req   = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n   = (e + 1 > N) ? N : e + 1;
            esw = therm(n);
            checks++;
            if (sw !== esw || ack !== (e >= 4))
                $display("FAIL dwell0 e=%0d got sw=%b ack=%b want sw=%b ack=%b",
                         e, sw, ack, esw, e >= 4);
            else passes++;
        end
    endtask

    task automatic test_reversal(input bit rerise);
        int el;
        bit eb;
        bit ei;
        do_reset();
        dwell = 4'd3;
        req   = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            if (e == 4) req = 1'b0;
            if (rerise && e == 8) req = 1'b1;
            tick();
            if (e <= 2) el = 1;
            else if (e == 3) el = 2;
            else if (e <= 6) el = 1;
            else if (rerise && e >= 8) el = 1;
            else el = 0;
            eb = rerise ? 1'b1 : (e < 10);
            ei = rerise ? 1'b0 : (e == 10);
            checks++;
            if (sw !== therm(el) || busy !== eb || idle !== ei)
                $display("FAIL reversal%0d e=%0d got sw=%b b=%b i=%b want sw=%b b=%b i=%b",
                         rerise, e, sw, busy, idle, therm(el), eb, ei);
            else passes++;
        end
    endtask

    task automatic test_coincident();
        do_reset();
        dwell = 4'd2;
        req   = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        req = 1'b0;
        tick();
        checks++;
        if (sw !== 4'b0001 || busy !== 1'b1)
            $display("FAIL coincident got sw=%b busy=%b want 0001 1", sw, busy);
        else passes++;
    endtask

    task automatic test_glitch();
        int low;
        do_reset();
        dwell = 4'd2;
        req   = 1'b1;
        for (int e = 0; e <= 8; e++) tick();
        checks++;
        if (ack !== 1'b1)
            $display("FAIL glitch_on got ack=%b want 1", ack);
        else passes++;
        req = 1'b0;
        tick();
        checks++;
        if (sw !== 4'b0111)
            $display("FAIL glitch_drop got sw=%b want 0111", sw);
        else passes++;
        req = 1'b1;
        low = 1;
        for (int c = 0; c < 10 && ack !== 1'b1; c++) begin
            tick();
            if (ack !== 1'b1) low++;
        end
        checks++;
        if (low !== 3 || sw !== 4'b1111)
            $display("FAIL glitch_ack_low got %0d cycles sw=%b want 3 1111", low, sw);
        else passes++;
    endtask

    task automatic test_random();
        int  m_lvl;
        int  m_rem;
        int  d;
        bit  m_ramp;
        bit  m_up;
        logic [6:0] exp_v;
        do_reset();
        m_lvl  = 0;
        m_rem  = 0;
        m_ramp = 1'b0;
        m_up   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = ~req;
            dwell = 4'($urandom_range(0, 3));
            rn    = ($urandom_range(0, 199) != 0);
            d     = (dwell == 0) ? 1 : int'(dwell);
            if (!rn) begin
                m_lvl  = 0;
                m_rem  = 0;
                m_ramp = 1'b0;
                m_up   = 1'b0;
            end else if (req != m_up) begin
                m_up   = req;
                m_lvl  = m_lvl + (req ? 1 : -1);
                m_rem  = d;
                m_ramp = 1'b1;
            end else if (m_ramp) begin
                m_rem--;
                if (m_rem == 0) begin
                    if ((m_up && m_lvl == N) || (!m_up && m_lvl == 0)) begin
                        m_ramp = 1'b0;
                    end else begin
                        m_lvl = m_lvl + (m_up ? 1 : -1);
                        m_rem = d;
                    end
                end
            end
            exp_v = {therm(m_lvl), !m_ramp && m_up, !m_ramp && !m_up, m_ramp};
            tick();
            checks++;
            if ({sw, ack, idle, busy} !== exp_v)
                $display("FAIL random c=%0d got sw/a/i/b=%b want %b",
                         c, {sw, ack, idle, busy}, exp_v);
            else passes++;
        end
        rn = 1'b1;
    endtask

    initial begin
        rn    = 1'b0;
        req   = 1'b0;
        dwell = 4'd0;
        test_reset();
        test_ramp_up_down();
        test_dwell_zero();
        test_reversal(1'b0);
        test_reversal(1'b1);
        test_coincident();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
